// File: rtl/leds_racer_core_n_if.sv
// leds_racer_core_n_if: frame/game-state bus between the racer core (master) and the LED-strip driver (slave).
interface leds_racer_core_n_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int POS_W       = 7
);
    logic [NUM_PLAYERS*POS_W-1:0] positions;
    logic [1:0]                   game_state;
    logic                         winner_valid;
    logic [2:0]                   winner_id;
    logic                         frame_req;
    logic                         frame_ack;

    modport master (
        output positions, game_state, winner_valid, winner_id, frame_req,
        input  frame_ack
    );

    modport slave (
        input  positions, game_state, winner_valid, winner_id, frame_req,
        output frame_ack
    );
endinterface

// File: rtl/leds_racer_core_n.sv
// leds_racer_core_n: N-player LEDs racer core with per-button sync/debounce, race FSM and frame req/ack.
// Define COUNTDOWN_EN to insert a COUNTDOWN_CLK_CNT-cycle countdown between IDLE and RACING.
module leds_racer_core_n #(
    parameter int NUM_PLAYERS       = 4,
    parameter int MAX_POS           = 109,
    parameter int DEBOUNCE_CLK_CNT  = 65536,
    parameter int COUNTDOWN_CLK_CNT = 1000000
) (
    input  logic                   clk,
    input  logic                   force_reset,
    input  logic [NUM_PLAYERS-1:0] player_inputs_i,
    leds_racer_core_n_if.master    bus
);
    localparam int POS_W = $clog2(MAX_POS + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CLK_CNT);

    typedef enum logic [1:0] {IDLE = 2'd0, RACING = 2'd1, FINISHED = 2'd2, COUNTDOWN = 2'd3} state_e;

    logic [NUM_PLAYERS-1:0]       s1_q, s2_q, deb_q, deb_d, press;
    logic [DB_W-1:0]              cnt_q [NUM_PLAYERS];
    logic [DB_W-1:0]              cnt_d [NUM_PLAYERS];
    logic [NUM_PLAYERS*POS_W-1:0] pos_q, pos_d;
    state_e                       state_q, state_d;
    logic [2:0]                   win_q, win_d;
    logic                         req_q, dirty;
`ifdef COUNTDOWN_EN
    localparam int CD_W = $clog2(COUNTDOWN_CLK_CNT);
    logic [CD_W-1:0]              cd_q, cd_d;
`endif

    // Counter restarts whenever the synced level matches the debounced one.
    always_comb begin
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_W'(DEBOUNCE_CLK_CNT - 1)) begin
                    deb_d[i] = s2_q[i];
                    press[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        win_d   = win_q;
`ifdef COUNTDOWN_EN
        cd_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|press) begin
`ifdef COUNTDOWN_EN
                    state_d = COUNTDOWN;
`else
                    state_d = RACING;
`endif
                end
            end
            RACING: begin
                for (int i = 0; i < NUM_PLAYERS; i++)
                    if (press[i] && pos_q[i*POS_W +: POS_W] != POS_W'(MAX_POS))
                        pos_d[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] + 1'b1;
                // Descending scan so the lowest finishing index wins a tie.
                for (int i = NUM_PLAYERS - 1; i >= 0; i--)
                    if (pos_d[i*POS_W +: POS_W] == POS_W'(MAX_POS)) begin
                        state_d = FINISHED;
                        win_d   = 3'(i);
                    end
            end
            FINISHED: begin
                for (int i = 0; i < NUM_PLAYERS; i++)
                    if (press[i] && 3'(i) == win_q) begin
                        state_d = IDLE;
                        pos_d   = '0;
                    end
            end
`ifdef COUNTDOWN_EN
            COUNTDOWN: begin
                cd_d    = (cd_q == CD_W'(COUNTDOWN_CLK_CNT - 1)) ? '0 : cd_q + 1'b1;
                state_d = (cd_q == CD_W'(COUNTDOWN_CLK_CNT - 1)) ? RACING : COUNTDOWN;
            end
`endif
            default: state_d = state_q;
        endcase
        dirty = (pos_d != pos_q) || (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (force_reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) cnt_q[i] <= '0;
            state_q <= IDLE;
            pos_q   <= '0;
            win_q   <= '0;
            req_q   <= 1'b1;
`ifdef COUNTDOWN_EN
            cd_q    <= '0;
`endif
        end else begin
            s1_q    <= player_inputs_i;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pos_q   <= pos_d;
            win_q   <= win_d;
            req_q   <= dirty | (req_q & ~bus.frame_ack);
`ifdef COUNTDOWN_EN
            cd_q    <= cd_d;
`endif
        end
    end

    assign bus.positions    = pos_q;
    assign bus.game_state   = state_q;
    assign bus.winner_valid = (state_q == FINISHED);
    assign bus.winner_id    = win_q;
    assign bus.frame_req    = req_q;
endmodule

// File: tb/tb_leds_racer_core_n.sv
// tb_leds_racer_core_n: table-driven, scoreboard-checked bench for leds_racer_core_n (4 players, MAX_POS=5, debounce 4).
module tb_leds_racer_core_n;
    localparam int NP = 4, MP = 5, POSW = 3;

    typedef struct {
        logic [11:0] pos;
        logic [1:0]  st;
        logic        req, wv;
        logic [2:0]  wid;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        bit         rst, ack;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       force_reset = 1'b1;
    logic [3:0] btn = '0;
    vec_t       vt [16];
    exp_t       sb [$];
    int         n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    leds_racer_core_n_if #(.NUM_PLAYERS(NP), .POS_W(POSW)) bus ();

    leds_racer_core_n #(
        .NUM_PLAYERS(NP), .MAX_POS(MP), .DEBOUNCE_CLK_CNT(4), .COUNTDOWN_CLK_CNT(10)
    ) dut (
        .clk(clk), .force_reset(force_reset), .player_inputs_i(btn), .bus(bus.master)
    );

    function automatic logic [11:0] pk(int a, int b, int c, int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic exp_t ex(logic [11:0] p, int st, bit req, bit wv, int wid);
        exp_t e;
        e.pos = p; e.st = 2'(st); e.req = req; e.wv = wv; e.wid = 3'(wid);
        return e;
    endfunction

    function automatic vec_t mkv(logic [3:0] m, bit rst, bit ack, exp_t e);
        vec_t v;
        v.mask = m; v.rst = rst; v.ack = ack; v.e = e;
        return v;
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if ({bus.positions, bus.game_state, bus.frame_req, bus.winner_valid, bus.winner_id} !==
            {e.pos, e.st, e.req, e.wv, e.wid}) begin
            n_bad++;
            $display("FAIL %s: got pos=%h st=%0d req=%b wv=%b wid=%0d, want pos=%h st=%0d req=%b wv=%b wid=%0d",
                     name, bus.positions, bus.game_state, bus.frame_req, bus.winner_valid, bus.winner_id,
                     e.pos, e.st, e.req, e.wv, e.wid);
        end
    endtask

    task automatic ack_pulse();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    task automatic press(logic [3:0] m);
        btn = m;
        tick(6);
        btn = '0;
        tick(8);
    endtask

    task automatic run_vec(int i);
        exp_t e;
        if (vt[i].rst) begin
            force_reset = 1'b1;
            tick();
            force_reset = 1'b0;
        end
        sb.push_back(vt[i].e);
        press(vt[i].mask);
        check($sformatf("vec%0d", i));
        if (vt[i].ack) begin
            e = vt[i].e;
            e.req = 1'b0;
            sb.push_back(e);
            ack_pulse();
            check($sformatf("vec%0d_ack", i));
        end
    endtask

    initial begin
        bus.frame_ack = 1'b0;
        vt[0]  = mkv(4'h2, 0, 1, ex(pk(0,0,0,0), 1, 1, 0, 0));
        vt[1]  = mkv(4'h5, 0, 1, ex(pk(1,0,1,0), 1, 1, 0, 0));
        vt[2]  = mkv(4'h5, 0, 1, ex(pk(2,0,2,0), 1, 1, 0, 0));
        vt[3]  = mkv(4'h5, 0, 1, ex(pk(3,0,3,0), 1, 1, 0, 0));
        vt[4]  = mkv(4'h5, 0, 1, ex(pk(4,0,4,0), 1, 1, 0, 0));
        vt[5]  = mkv(4'h5, 0, 1, ex(pk(5,0,5,0), 2, 1, 1, 0));
        vt[6]  = mkv(4'h4, 0, 0, ex(pk(5,0,5,0), 2, 0, 1, 0));
        vt[7]  = mkv(4'h1, 0, 1, ex(pk(0,0,0,0), 0, 1, 0, 0));
        vt[8]  = mkv(4'h8, 0, 0, ex(pk(0,0,0,0), 1, 1, 0, 0));
        vt[9]  = mkv(4'h8, 0, 0, ex(pk(0,0,0,1), 1, 1, 0, 0));
        vt[10] = mkv(4'h8, 0, 0, ex(pk(0,0,0,2), 1, 1, 0, 0));
        vt[11] = mkv(4'h8, 0, 0, ex(pk(0,0,0,3), 1, 1, 0, 0));
        vt[12] = mkv(4'h1, 1, 1, ex(pk(0,0,0,0), 1, 1, 0, 0));
        vt[13] = mkv(4'hB, 0, 1, ex(pk(1,1,0,1), 1, 1, 0, 0));
        vt[14] = mkv(4'h9, 0, 1, ex(pk(2,1,0,2), 1, 1, 0, 0));
        vt[15] = mkv(4'h1, 0, 1, ex(pk(3,1,0,2), 1, 1, 0, 0));

        tick(2);
        force_reset = 1'b0;
        sb.push_back(ex(pk(0,0,0,0), 0, 1, 0, 0));
        check("reset");
        sb.push_back(ex(pk(0,0,0,0), 0, 0, 0, 0));
        ack_pulse();
        check("reset_ack");

`ifdef COUNTDOWN_EN
        btn = 4'h2;
        tick(6);
        sb.push_back(ex(pk(0,0,0,0), 3, 1, 0, 0));
        check("cd_enter");
        btn = 4'h3;
        tick(3);
        ack_pulse();
        sb.push_back(ex(pk(0,0,0,0), 3, 0, 0, 0));
        check("cd_ack");
        tick(5);
        sb.push_back(ex(pk(0,0,0,0), 3, 0, 0, 0));
        check("cd_last");
        tick();
        sb.push_back(ex(pk(0,0,0,0), 1, 1, 0, 0));
        check("cd_racing");
        btn = '0;
        tick(10);
        sb.push_back(ex(pk(0,0,0,0), 1, 1, 0, 0));
        check("cd_release");
`else
        btn = 4'h2;
        tick(2);
        btn = '0;
        sb.push_back(ex(pk(0,0,0,0), 0, 0, 0, 0));
        tick(10);
        check("glitch");

        for (int i = 0; i < 12; i++) run_vec(i);

        btn = 4'h8;
        tick(5);
        bus.frame_ack = 1'b1;
        sb.push_back(ex(pk(0,0,0,4), 1, 1, 0, 0));
        tick();
        bus.frame_ack = 1'b0;
        check("ack_same_cycle");
        sb.push_back(ex(pk(0,0,0,4), 1, 1, 0, 0));
        tick();
        check("ack_same_hold");
        btn = '0;
        tick(8);
        sb.push_back(ex(pk(0,0,0,4), 1, 0, 0, 0));
        ack_pulse();
        check("single_ack");

        for (int i = 12; i < 16; i++) run_vec(i);

        btn = 4'h1;
        tick(3);
        force_reset = 1'b1;
        sb.push_back(ex(pk(0,0,0,0), 0, 1, 0, 0));
        tick();
        force_reset = 1'b0;
        check("reset_mid");
        sb.push_back(ex(pk(0,0,0,0), 0, 1, 0, 0));
        tick(5);
        check("held_pre");
        sb.push_back(ex(pk(0,0,0,0), 1, 1, 0, 0));
        tick();
        check("held_press");
        btn = '0;
        tick(10);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
